pkt_rr_arbiter: RTL
===================

# pkt_rr_arbiter

Packet-atomic round-robin arbiter that merges N parser output streams into one AXI4-Stream master. Each input carries packets of one metadata beat (TUSER=1) followed by data beats, ending with TLAST. A grant is held for a whole packet, so metadata and payload from different sources never interleave. The block sits between the per-port parser/slave instances and the shared downstream consumer.

## Interface
- N_REQ, 4, number of input streams (2..8)
- DATA_W, 512, TDATA width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_tvalid  in  N_REQ  per-input TVALID
- s_tready  out  N_REQ  per-input TREADY
- s_tdata  in  N_REQ*DATA_W  input i occupies bits [i*DATA_W +: DATA_W]
- s_tlast  in  N_REQ  per-input TLAST
- s_tuser  in  N_REQ  per-input TUSER (1 = metadata beat)
- m_tvalid  out  1  output TVALID
- m_tready  in  1  output TREADY
- m_tdata  out  DATA_W  output TDATA
- m_tlast  out  1  output TLAST
- m_tuser  out  1  output TUSER
- m_tid  out  clog2(N_REQ)  source index of the current output beat
- busy  out  1  high while a grant is held (state LOCK)
- hdr_err  out  1  sticky: a packet started with TUSER=0
- pkt_cnt  out  16  packets forwarded (counted on output TLAST handshake), wraps at 0xFFFF→0

## Operation
- States: IDLE, LOCK. Registers: grant index gnt, rotating pointer rr_ptr, output register.
- IDLE: if any s_tvalid bit set, select the first asserted index searching rr_ptr, rr_ptr+1, … mod N_REQ; load gnt, go LOCK. No input beat is accepted in IDLE; all s_tready = 0.
- LOCK: s_tready[gnt] = (!m_tvalid || m_tready); all other s_tready = 0. Combinational from m_tvalid/m_tready only, never from s_tvalid.
- Accepted beat (s_tvalid[gnt] && s_tready[gnt]) loads output register: m_tdata/m_tlast/m_tuser from input gnt, m_tid = gnt, m_tvalid = 1.
- Output register with no accept and m_tready=1: m_tvalid → 0. With m_tready=0: all outputs hold.
- Accepted beat with s_tlast=1: next state IDLE, rr_ptr ← (gnt+1) mod N_REQ.
- First accepted beat of each grant with s_tuser=0: hdr_err ← 1 (beat still forwarded unchanged).
- pkt_cnt increments on m_tvalid && m_tready && m_tlast.
- Non-granted inputs are never dropped; they wait with s_tready=0.

## Timing
- Reset values: s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0, m_tid=0, busy=0, hdr_err=0, pkt_cnt=0; state IDLE, rr_ptr=0, gnt=0.
- Arbitration: request visible cycle t → LOCK and s_tready in cycle t+1 → m_tvalid cycle t+2.
- Within a packet: 1 beat per cycle with m_tready held high; 1-cycle input-to-output latency.
- Packet-to-packet: exactly one IDLE bubble cycle after each TLAST accept.
- Reset asserted mid-packet: all state cleared immediately; partial packet abandoned; no resumption after release.
- Single requester: re-granted every packet after one bubble cycle.
- gnt does not change while in LOCK regardless of other s_tvalid activity.

## Configuration
- PKT_ARB_PRIO_EN defined: input 0 has strict priority in IDLE (granted whenever s_tvalid[0]=1); round-robin applies among inputs 1..N_REQ-1 only; rr_ptr never points to 0. Still packet-atomic: no preemption of a held grant.
- Undefined: pure round-robin across all N_REQ inputs as above.

## Test plan
- Reset, then input 2 sends 4-beat packet (meta 0xA, data 0x1,0x2,0x3 last), m_tready=1 → m_tid=2, m_tuser=1,0,0,0, m_tlast on 4th beat, first m_tvalid 2 cycles after s_tvalid, pkt_cnt=1.
- All 4 inputs continuously valid, 4-beat packets → grant order 0,1,2,3,0; no interleave; one bubble between packets; pkt_cnt=5 after 5 packets.
- Input 1 granted, m_tready toggled 1010… → each beat delivered exactly once in order; outputs stable while m_tready=0.
- Input 0 packet starts with TUSER=0 → forwarded, hdr_err=1 and stays 1 after later good packets.
- Reset pulsed on 2nd beat of a packet → all outputs 0 next edge; after release new packet from input 3 forwarded cleanly starting with meta beat.
- PKT_ARB_PRIO_EN defined, inputs 0 and 1 always valid → only input 0 granted; undefined → alternating 0,1.

Source files
------------

// File: rtl/pkt_rr_arbiter.sv
// Packet-atomic round-robin arbiter merging N_REQ AXI4-Stream inputs.
// Define PKT_ARB_PRIO_EN to give input 0 strict priority at arbitration.
module pkt_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 512,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        s_tvalid,
  output logic [N_REQ-1:0]        s_tready,
  input  logic [N_REQ*DATA_W-1:0] s_tdata,
  input  logic [N_REQ-1:0]        s_tlast,
  input  logic [N_REQ-1:0]        s_tuser,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tlast,
  output logic                    m_tuser,
  output logic [ID_W-1:0]         m_tid,
  output logic                    busy,
  output logic                    hdr_err,
  output logic [15:0]             pkt_cnt
);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     gnt_q, gnt_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic                first_q, first_d;
  logic                vld_q, vld_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                user_q, user_d;
  logic [ID_W-1:0]     tid_q, tid_d;
  logic                err_q, err_d;
  logic [15:0]         cnt_q, cnt_d;

  logic [ID_W:0]       sum;
  logic [ID_W:0]       nxt;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_vld;
  logic                out_free;
  logic                acc;
`ifdef PKT_ARB_PRIO_EN
  logic [ID_W-1:0]     base;
`endif

  // Pick the next requester, scanning from the rotating pointer.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = '0;
`ifdef PKT_ARB_PRIO_EN
    base = (rr_q == '0) ? ID_W'(1) : rr_q;
    for (int k = N_REQ - 2; k >= 0; k--) begin
      sum = {1'b0, base} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_REQ))
        sum = sum - (ID_W+1)'(N_REQ - 1);
      if (s_tvalid[sum[ID_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = sum[ID_W-1:0];
      end
    end
    if (s_tvalid[0]) begin
      pick_vld = 1'b1;
      pick_idx = '0;
    end
`else
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_REQ))
        sum = sum - (ID_W+1)'(N_REQ);
      if (s_tvalid[sum[ID_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = sum[ID_W-1:0];
      end
    end
`endif
  end

  // Next-state, grant handshake and output register update.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    first_d  = first_q;
    vld_d    = vld_q;
    data_d   = data_q;
    last_d   = last_q;
    user_d   = user_q;
    tid_d    = tid_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    s_tready = '0;
    out_free = !vld_q || m_tready;
    acc      = 1'b0;
    nxt      = {1'b0, gnt_q} + (ID_W+1)'(1);
    if (nxt >= (ID_W+1)'(N_REQ))
      nxt = '0;
`ifdef PKT_ARB_PRIO_EN
    if (nxt == '0)
      nxt = (ID_W+1)'(1);
`endif

    if (vld_q && m_tready) begin
      vld_d = 1'b0;
      if (last_q)
        cnt_d = cnt_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_idx;
          first_d = 1'b1;
          state_d = LOCK;
        end
      end
      LOCK: begin
        s_tready[gnt_q] = out_free;
        acc = s_tvalid[gnt_q] && out_free;
        if (acc) begin
          vld_d   = 1'b1;
          data_d  = s_tdata[int'(gnt_q)*DATA_W +: DATA_W];
          last_d  = s_tlast[gnt_q];
          user_d  = s_tuser[gnt_q];
          tid_d   = gnt_q;
          first_d = 1'b0;
          if (first_q && !s_tuser[gnt_q])
            err_d = 1'b1;
          if (s_tlast[gnt_q]) begin
            state_d = IDLE;
`ifdef PKT_ARB_PRIO_EN
            if (gnt_q != '0)
              rr_d = nxt[ID_W-1:0];
`else
            rr_d = nxt[ID_W-1:0];
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      first_q <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= 1'b0;
      tid_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      first_q <= first_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      last_q  <= last_d;
      user_q  <= user_d;
      tid_q   <= tid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_tvalid = vld_q;
  assign m_tdata  = data_q;
  assign m_tlast  = last_q;
  assign m_tuser  = user_q;
  assign m_tid    = tid_q;
  assign busy     = (state_q == LOCK);
  assign hdr_err  = err_q;
  assign pkt_cnt  = cnt_q;

endmodule
